spi_ram_ctrl: RTL
=================

// Module: spi_ram_ctrl
// PURPOSE
//  Single-port byte RAM with command decoder. Sits directly downstream of the SPI slave.
//  Consumes each 10-bit frame (opcode din[9:8], payload din[7:0]) when rx_valid is high.
//  Performs address-latch, write, and read operations.
//  Returns read bytes on dout with a one-cycle tx_valid pulse, which the slave shifts out on MISO.
// PARAMETERS
//  MEM_DEPTH  256  number of byte locations; must equal 2**ADDR_SIZE
//  ADDR_SIZE  8    address width; must be <= 8, uses din[ADDR_SIZE-1:0]
//  AUTO_INC   1    1: wr_addr increments (mod MEM_DEPTH) after every accepted data write
// PORTS
//  clk       in   1   rising-edge clock
//  rst       in   1   asynchronous, active-high reset
//  din       in   10  frame from SPI slave: [9:8] opcode, [7:0] payload
//  rx_valid  in   1   din valid this cycle, one-cycle pulse per frame
//  dout      out  8   read data, held until the next read response
//  tx_valid  out  1   one-cycle pulse, dout valid
//  busy      out  1   high in RD_FETCH/RD_RESP
//  seq_err   out  1   one-cycle pulse, frame rejected
// BEHAVIOUR
//  Reset: dout=0, tx_valid=0, busy=0, seq_err=0, wr_addr=0, rd_addr=0.
//   Reset also clears wr_armed and rd_armed and sets state=IDLE. Memory contents are not reset.
//  Opcodes (acted on only when rx_valid=1 and state=IDLE):
//   00 WR_ADDR: wr_addr<=din[ADDR_SIZE-1:0]; wr_armed<=1.
//   01 WR_DATA: if wr_armed, mem[wr_addr]<=din[7:0], and wr_addr+1 if AUTO_INC (MEM_DEPTH-1 wraps to 0).
//      If not wr_armed: no write, seq_err pulse. wr_armed persists after a write.
//   10 RD_ADDR: rd_addr<=din[ADDR_SIZE-1:0]; rd_armed<=1.
//   11 RD_DATA: if rd_armed, go to RD_FETCH and clear rd_armed. Otherwise seq_err pulse, stay IDLE.
//  FSM: IDLE -> RD_FETCH (on accepted RD_DATA) -> RD_RESP -> IDLE, one cycle each.
//   RD_FETCH: registered read rdata<=mem[rd_addr].
//   RD_RESP: dout<=rdata; tx_valid=1 for exactly this one cycle.
//  Latency: RD_DATA sampled at edge N. dout updates and tx_valid rises at edge N+2; tx_valid falls at N+3.
//  Writes take effect at the sampling edge. A RD_DATA at the very next edge returns the new byte.
//  rx_valid while busy=1: frame dropped, seq_err pulses the next cycle, no state or register change.
//  seq_err is registered, asserted the cycle after the offending frame's edge.
//  Address payload bits din[7:ADDR_SIZE] are ignored. Write data always uses all 8 bits.
//  WR_ADDR/RD_ADDR re-issued while already armed simply overwrite the address.
//  rst mid-read: FSM returns to IDLE immediately and tx_valid drops; the pending response is lost.
// TESTING
//  T1 write/read: rst, WR_ADDR 0x010, WR_DATA 0x1A5, RD_ADDR 0x210, RD_DATA 0x300
//     -> tx_valid one pulse 2 edges after RD_DATA, dout=0xA5.
//  T2 auto-inc wrap: WR_ADDR 0x0FF; WR_DATA 0x111; WR_DATA 0x122; read 0xFF and 0x00
//     -> 0x11 and 0x22.
//  T3 sequence errors: after rst, WR_DATA 0x155 -> seq_err pulse, mem[0] unchanged.
//     Then RD_DATA 0x300 -> seq_err, no tx_valid.
//  T4 re-arm: RD_ADDR, RD_DATA, then a second RD_DATA without RD_ADDR
//     -> first gives tx_valid, second gives seq_err.
//  T5 busy drop: RD_DATA then rx_valid WR_ADDR 0x033 on the next edge
//     -> seq_err, wr_addr unchanged, read response still correct.
//  T6 reset mid-op: assert rst during RD_FETCH -> tx_valid never rises, all outputs 0, state IDLE.

Source files
------------

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: byte RAM behind an SPI slave. Each 10-bit frame carries a 2-bit opcode
// and an 8-bit payload. The opcodes latch a write address, write a byte, latch a read
// address, or start a read. Read bytes come back on dout with a one-cycle tx_valid pulse.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned AUTO_INC  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       busy,
    output logic       seq_err
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRdFetch = 2'd1,
        StRdResp  = 2'd2
    } state_t;

    localparam logic [1:0] OpWrAddr = 2'b00;
    localparam logic [1:0] OpWrData = 2'b01;
    localparam logic [1:0] OpRdAddr = 2'b10;
    localparam logic [1:0] OpRdData = 2'b11;

    state_t               r_state;
    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic                 r_wr_armed;
    logic                 r_rd_armed;
    logic [7:0]           r_mem [MEM_DEPTH];
    logic [7:0]           r_rdata;
    logic [7:0]           r_dout;
    logic                 r_tx_valid;
    logic                 r_busy;
    logic                 r_seq_err;

    logic [1:0]           w_op;
    logic [ADDR_SIZE-1:0] w_addr;
    logic                 w_wr_en;

    assign w_op    = din[9:8];
    assign w_addr  = din[ADDR_SIZE-1:0];
    // A data write happens only for a frame accepted in idle with the write side armed.
    assign w_wr_en = rx_valid && (r_state == StIdle) && (w_op == OpWrData) && r_wr_armed;

    // Memory array and registered read port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= din[7:0];
        end
        if (r_state == StRdFetch) begin
            r_rdata <= r_mem[r_rd_addr];
        end
    end

    // Command decoder and read-response FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_wr_armed <= 1'b0;
            r_rd_armed <= 1'b0;
            r_dout     <= 8'h00;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_seq_err  <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            r_seq_err  <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (rx_valid) begin
                        unique case (w_op)
                            OpWrAddr: begin
                                r_wr_addr  <= w_addr;
                                r_wr_armed <= 1'b1;
                            end
                            OpWrData: begin
                                if (r_wr_armed) begin
                                    if (AUTO_INC != 0) begin
                                        r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
                                    end
                                end else begin
                                    r_seq_err <= 1'b1;
                                end
                            end
                            OpRdAddr: begin
                                r_rd_addr  <= w_addr;
                                r_rd_armed <= 1'b1;
                            end
                            OpRdData: begin
                                if (r_rd_armed) begin
                                    r_rd_armed <= 1'b0;
                                    r_busy     <= 1'b1;
                                    r_state    <= StRdFetch;
                                end else begin
                                    r_seq_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                StRdFetch: begin
                    // Frames arriving while busy are dropped and flagged.
                    r_seq_err <= rx_valid;
                    r_state   <= StRdResp;
                end
                StRdResp: begin
                    r_seq_err  <= rx_valid;
                    r_dout     <= r_rdata;
                    r_tx_valid <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign dout     = r_dout;
    assign tx_valid = r_tx_valid;
    assign busy     = r_busy;
    assign seq_err  = r_seq_err;

endmodule
